alu_issue_seq: RTL and testbench
================================

# alu_issue_seq

Issue sequencer for the VLIW execute stage. Accepts one bundle of NSLOT slot instructions over a valid/ready handshake and reads operands from an internal register file. Executes the slots in order, one per cycle, through a single shared combinational ALU, then writes each result back and reports it on a writeback strobe. It drives the ALU's op/in1/in2 inputs, consumes its result, and owns the architectural registers and zero flag.

## Interface

Parameters
- NSLOT, 2: slots per bundle (1..4)
- NREG, 8: register count; address width RW = clog2(NREG)

Ports
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- bnd_valid  in  1  bundle offered
- bnd_ready  out  1  bundle accepted when high with bnd_valid
- bnd_data  in  NSLOT*(2+3*RW)  slot k at bits [k*(2+3*RW) +: 2+3*RW]; fields MSB→LSB: op[1:0], rd, rs1, rs2
- ld_en  in  1  host register load
- ld_addr  in  RW  load address
- ld_data  in  32  load value
- alu_op  out  2  to ALU
- alu_in1  out  32  to ALU
- alu_in2  out  32  to ALU
- alu_ans  in  32  ALU result, same cycle
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  RW  written register
- wb_data  out  32  written value
- zflag  out  1  zero flag of last non-NOP slot
- dbg_addr  in  RW  debug read address
- dbg_data  out  32  combinational register read

## Operation

- Ops: 0 ADD, 1 AND, 2 SHR (in1 shifted by in2), 3 NOP. The ALU performs the arithmetic; this block does none.
- r0 reads as 0; writes to r0 are dropped, but wb_valid still pulses with wb_data = ALU result.
- FSM states: IDLE, EXEC.
  - IDLE: bnd_ready = 1. On bnd_valid, latch bnd_data into a bundle register, clear slot counter, go to EXEC.
  - EXEC: bnd_ready = 0. Present slot[cnt]: alu_op = op, alu_in1 = R[rs1], alu_in2 = R[rs2].
    - On the clock edge, if op ≠ 3: write alu_ans to R[rd]; zflag ← (alu_ans == 0); wb_valid/wb_rd/wb_data registered for the next cycle.
    - NOP: no write, no wb_valid, zflag unchanged.
    - cnt == NSLOT-1 → IDLE; else cnt+1.
- Slots execute sequentially. A later slot reads registers already written by earlier slots in the same bundle (RAW within a bundle is honoured).
- In IDLE: alu_op = 3 and alu_in1 = alu_in2 = 0.
- ld_en is honoured only in IDLE (write R[ld_addr] ← ld_data; r0 excepted). It is ignored in EXEC.
- If ld_en and bnd_valid arrive in the same IDLE cycle, both take effect: the load writes and the bundle is accepted. Slot 0 sees the loaded value.
- zflag is computed locally from alu_ans; no ALU-side flag is used.

## Timing

- Reset (async assert, sync release): state IDLE, cnt 0, all registers 0, zflag 0, wb_valid 0, wb_rd 0, wb_data 0, bundle register 0.
- Bundle accepted at edge T. Slot k is presented during cycle T+1+k, written at the end of that cycle, and its wb_valid is high during cycle T+2+k.
- bnd_ready returns high in cycle T+1+NSLOT. Throughput is one bundle per NSLOT+1 cycles.
- No wb backpressure: a consumer must accept wb_valid every cycle.
- Reset mid-EXEC aborts the bundle. Slots already committed are lost, because reset clears the register file.
- bnd_data may change after acceptance without effect.

## Structure

- Shared package alu_pkg: op encodings (OP_ADD=0, OP_AND=1, OP_SHR=2, OP_NOP=3), slot field widths and offsets, FSM state encoding. The ALU and this block import it.
- One natural sub-module, alu_regfile: NREG×32, two combinational read ports, debug read port, one write port, r0 forced zero, async clear.

## Test plan

Bench pairs the block with a behavioural ALU model; NSLOT=2, NREG=8.

1. Load r1=5, r2=3; bundle {slot0 ADD r3←r1,r2; slot1 AND r4←r3,r2} → wb r3=8 in cycle T+2, then wb r4=0 in T+3 with zflag=1; dbg r4=0.
2. Load r1=0x100, r2=4; bundle {SHR r5←r1,r2; NOP} → one wb_valid (r5=0x10), zflag=0, bnd_ready high at T+3.
3. Bundle {ADD r0←r1,r1; ADD r6←r0,r2} with r1=7, r2=2 → wb r0 data 14, r0 stays 0, r6=2.
4. bnd_valid held high for 3 bundles → accepts exactly every 3rd cycle; alu_op=3 in every IDLE cycle.
5. ld_en r1=9 during EXEC → ignored, r1 unchanged; ld_en r1=9 with bnd_valid in IDLE, slot0 ADD r2←r1,r1 → wb r2=18.
6. rst_n low during slot 1 → immediate IDLE, wb_valid=0, all dbg reads 0, bnd_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the VLIW execute stage: op encodings, slot field
// layout helpers and the issue sequencer FSM state encoding.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 2;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_AND = 2'd1,
        OP_SHR = 2'd2,
        OP_NOP = 2'd3
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    // Slot layout, MSB to LSB: op, rd, rs1, rs2 (register fields are rw bits)
    function automatic int slot_w(input int rw);
        return OP_W + 3 * rw;
    endfunction

    function automatic int rs2_lsb(input int rw);
        return 0 * rw;
    endfunction

    function automatic int rs1_lsb(input int rw);
        return rw;
    endfunction

    function automatic int rd_lsb(input int rw);
        return 2 * rw;
    endfunction

    function automatic int op_lsb(input int rw);
        return 3 * rw;
    endfunction

endpackage

// File: rtl/alu_issue_seq_if.sv
// Bus bundle of the issue sequencer: bundle handshake, host load port,
// ALU drive/return, writeback strobe, zero flag and debug read port.
//
// Handshake: a bundle transfers on a rising clk edge where bnd_valid and
// bnd_ready are both high. bnd_ready does not depend on bnd_valid; the
// producer may change bnd_data freely once the transfer has happened.
interface alu_issue_seq_if
    import alu_pkg::*;
#(
    parameter int NSLOT = 2,
    parameter int NREG  = 8
);
    localparam int RW = $clog2(NREG);
    localparam int BW = NSLOT * slot_w(RW);

    logic              bnd_valid;
    logic              bnd_ready;
    logic [BW-1:0]     bnd_data;
    logic              ld_en;
    logic [RW-1:0]     ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic [DATA_W-1:0] alu_ans;
    logic              wb_valid;
    logic [RW-1:0]     wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              zflag;
    logic [RW-1:0]     dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    state_t            dbg_state;

    modport master (
        output bnd_valid, bnd_data, ld_en, ld_addr, ld_data, alu_ans, dbg_addr,
        input  bnd_ready, alu_op, alu_in1, alu_in2, wb_valid, wb_rd, wb_data,
               zflag, dbg_data, dbg_state
    );

    modport slave (
        input  bnd_valid, bnd_data, ld_en, ld_addr, ld_data, alu_ans, dbg_addr,
        output bnd_ready, alu_op, alu_in1, alu_in2, wb_valid, wb_rd, wb_data,
               zflag, dbg_data, dbg_state
    );

endinterface

// File: rtl/alu_regfile.sv
// Architectural register file: NREG x 32, two operand read ports, one debug
// read port, one write port. r0 always reads zero and ignores writes.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREG = 8,
    localparam int RW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RW-1:0]     ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [RW-1:0]     ra2,
    output logic [DATA_W-1:0] rd2,
    input  logic [RW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [RW-1:0]     wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];

    // Next register contents: single write, r0 never written
    always_comb begin
        mem_d = mem_q;
        if (we && (wa != '0)) begin
            mem_d[wa] = wd;
        end
    end

    // Register storage, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Combinational reads with r0 forced to zero
    always_comb begin
        rd1      = (ra1 == '0)      ? '0 : mem_q[ra1];
        rd2      = (ra2 == '0)      ? '0 : mem_q[ra2];
        dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];
    end

endmodule

// File: rtl/alu_issue_seq.sv
// Issue sequencer: accepts a bundle of NSLOT slots, executes them one per
// cycle through the external shared ALU, writes results back and reports
// each non-NOP result on a one-cycle writeback strobe.
module alu_issue_seq
    import alu_pkg::*;
#(
    parameter int NSLOT = 2,
    parameter int NREG  = 8
) (
    input  logic clk,
    input  logic rst_n,
    alu_issue_seq_if.slave bus
);

    localparam int RW = $clog2(NREG);
    localparam int SW = slot_w(RW);
    localparam int BW = NSLOT * SW;
    localparam int CW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bnd_q, bnd_d;
    logic              zflag_q, zflag_d;
    logic              wb_valid_q, wb_valid_d;
    logic [RW-1:0]     wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic [SW-1:0]     slots [NSLOT];
    logic [SW-1:0]     slot;
    op_t               slot_op;
    logic [RW-1:0]     slot_rd, slot_rs1, slot_rs2;

    logic [DATA_W-1:0] rs1_val, rs2_val;
    logic              rf_we;
    logic [RW-1:0]     rf_wa;
    logic [DATA_W-1:0] rf_wd;

    logic              bnd_ready;
    op_t               alu_op;
    logic [DATA_W-1:0] alu_in1, alu_in2;

    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        assign slots[k] = bnd_q[k*SW +: SW];
    end

    // Decode the slot selected by the counter
    always_comb begin
        slot     = slots[cnt_q];
        slot_op  = op_t'(slot[op_lsb(RW) +: OP_W]);
        slot_rd  = slot[rd_lsb(RW)  +: RW];
        slot_rs1 = slot[rs1_lsb(RW) +: RW];
        slot_rs2 = slot[rs2_lsb(RW) +: RW];
    end

    alu_regfile #(.NREG(NREG)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra1      (slot_rs1),
        .rd1      (rs1_val),
        .ra2      (slot_rs2),
        .rd2      (rs2_val),
        .dbg_addr (bus.dbg_addr),
        .dbg_data (bus.dbg_data),
        .we       (rf_we),
        .wa       (rf_wa),
        .wd       (rf_wd)
    );

    // Next-state, ALU drive and register-file write selection
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bnd_d      = bnd_q;
        zflag_d    = zflag_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        bnd_ready  = 1'b0;
        alu_op     = OP_NOP;
        alu_in1    = '0;
        alu_in2    = '0;
        rf_we      = 1'b0;
        rf_wa      = '0;
        rf_wd      = '0;
        case (state_q)
            ST_IDLE: begin
                bnd_ready = 1'b1;
                // Host loads only land while no bundle is in flight
                if (bus.ld_en) begin
                    rf_we = 1'b1;
                    rf_wa = bus.ld_addr;
                    rf_wd = bus.ld_data;
                end
                if (bus.bnd_valid) begin
                    bnd_d   = bus.bnd_data;
                    cnt_d   = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op  = slot_op;
                alu_in1 = rs1_val;
                alu_in2 = rs2_val;
                if (slot_op != OP_NOP) begin
                    rf_we      = 1'b1;
                    rf_wa      = slot_rd;
                    rf_wd      = bus.alu_ans;
                    zflag_d    = (bus.alu_ans == '0);
                    wb_valid_d = 1'b1;
                    wb_rd_d    = slot_rd;
                    wb_data_d  = bus.alu_ans;
                end
                if (cnt_q == CW'(NSLOT - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state, bundle register, flag and writeback registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bnd_q      <= '0;
            zflag_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bnd_q      <= bnd_d;
            zflag_q    <= zflag_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign bus.bnd_ready = bnd_ready;
    assign bus.alu_op    = alu_op;
    assign bus.alu_in1   = alu_in1;
    assign bus.alu_in2   = alu_in2;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.zflag     = zflag_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: behavioural ALU, directed scenarios and random
// bundles checked against a bundle-level reference model.
module tb_alu_issue_seq;
    import alu_pkg::*;

    localparam int NSLOT = 2;
    localparam int NREG  = 8;
    localparam int RW    = $clog2(NREG);
    localparam int SW    = 2 + 3 * RW;
    localparam int BW    = NSLOT * SW;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_seq_if #(.NSLOT(NSLOT), .NREG(NREG)) bus ();

    alu_issue_seq #(.NSLOT(NSLOT), .NREG(NREG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- behavioural ALU ----------------
    function automatic logic [31:0] alu_fn(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a & b;
            2'd2:    return a >> b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb bus.alu_ans = alu_fn(bus.alu_op, bus.alu_in1, bus.alu_in2);

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        int          cyc;
        logic [RW-1:0] rd;
        logic [31:0] data;
        bit          z;
    } wb_t;

    typedef struct {
        int          cyc;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } pres_t;

    logic [31:0] ref_r [NREG];
    bit          z_ref     = 1'b0;
    int          idle_from = 0;
    wb_t         exp_wb_q[$];
    pres_t       exp_pres_q[$];

    // A bundle accepted in cycle c runs slot k in cycle c+1+k; its result
    // shows on the writeback strobe in cycle c+2+k.
    function automatic void run_bundle(input logic [BW-1:0] b, input int c);
        for (int k = 0; k < NSLOT; k++) begin
            logic [SW-1:0] s;
            logic [1:0]    op;
            int            rd, rs1, rs2;
            logic [31:0]   va, vb, res;
            s   = b[k*SW +: SW];
            op  = s[SW-1 -: 2];
            rd  = int'(s[2*RW +: RW]);
            rs1 = int'(s[RW +: RW]);
            rs2 = int'(s[0 +: RW]);
            va  = ref_r[rs1];
            vb  = ref_r[rs2];
            res = alu_fn(op, va, vb);
            exp_pres_q.push_back('{c + 1 + k, op, va, vb});
            if (op != 2'd3) begin
                exp_wb_q.push_back('{c + 2 + k, RW'(rd), res, (res == 32'd0)});
                if (rd != 0) ref_r[rd] = res;
            end
        end
    endfunction

    // Cycle monitor, sampled on the falling edge
    always @(negedge clk) begin
        bit exp_ready;
        if (!rst_n) begin
            check("rst_wb_valid", bus.wb_valid, 0);
            check("rst_wb_rd", bus.wb_rd, 0);
            check("rst_wb_data", bus.wb_data, 0);
            check("rst_zflag", bus.zflag, 0);
            check("rst_ready", bus.bnd_ready, 1);
            for (int i = 0; i < NREG; i++) ref_r[i] = 32'd0;
            z_ref     = 1'b0;
            idle_from = 0;
            exp_wb_q.delete();
            exp_pres_q.delete();
        end else begin
            exp_ready = (cyc >= idle_from);
            check("bnd_ready", bus.bnd_ready, exp_ready);
            check("fsm_state", (bus.dbg_state == ST_EXEC), !exp_ready);
            if (exp_wb_q.size() > 0 && exp_wb_q[0].cyc == cyc) begin
                check("wb_valid", bus.wb_valid, 1);
                check("wb_rd", bus.wb_rd, exp_wb_q[0].rd);
                check("wb_data", bus.wb_data, exp_wb_q[0].data);
                z_ref = exp_wb_q[0].z;
                void'(exp_wb_q.pop_front());
            end else begin
                check("wb_valid_idle", bus.wb_valid, 0);
            end
            check("zflag", bus.zflag, z_ref);
            if (exp_pres_q.size() > 0 && exp_pres_q[0].cyc == cyc) begin
                check("alu_op", bus.alu_op, exp_pres_q[0].op);
                check("alu_in1", bus.alu_in1, exp_pres_q[0].a);
                check("alu_in2", bus.alu_in2, exp_pres_q[0].b);
                void'(exp_pres_q.pop_front());
            end
            if (exp_ready) begin
                check("idle_alu_op", bus.alu_op, 3);
                check("idle_alu_in1", bus.alu_in1, 0);
                check("idle_alu_in2", bus.alu_in2, 0);
                check("dbg_read", bus.dbg_data, ref_r[bus.dbg_addr]);
                if (bus.ld_en && bus.ld_addr != '0) ref_r[bus.ld_addr] = bus.ld_data;
                if (bus.bnd_valid) begin
                    run_bundle(bus.bnd_data, cyc);
                    idle_from = cyc + 1 + NSLOT;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [SW-1:0] mk_slot(input logic [1:0] op, input int rd,
                                              input int rs1, input int rs2);
        return {op, RW'(rd), RW'(rs1), RW'(rs2)};
    endfunction

    function automatic logic [31:0] rand_val();
        return ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : 32'($urandom);
    endfunction

    function automatic logic [BW-1:0] rand_bundle();
        logic [BW-1:0] b;
        for (int k = 0; k < NSLOT; k++) begin
            b[k*SW +: SW] = mk_slot(2'($urandom_range(0, 3)), $urandom_range(0, NREG - 1),
                                    $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1));
        end
        return b;
    endfunction

    task automatic do_load(input int addr, input logic [31:0] data);
        bus.ld_en   = 1'b1;
        bus.ld_addr = RW'(addr);
        bus.ld_data = data;
        @(posedge clk); #1;
        bus.ld_en   = 1'b0;
    endtask

    // Offers a bundle and returns one step into the first EXEC cycle
    task automatic send_bundle(input logic [BW-1:0] b);
        bit acc;
        acc = 1'b0;
        bus.bnd_valid = 1'b1;
        bus.bnd_data  = b;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = bus.bnd_ready;
            @(posedge clk); #1;
            bus.ld_en = 1'b0;
        end
        bus.bnd_valid = 1'b0;
        bus.bnd_data  = BW'($urandom);
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        repeat (NSLOT) @(posedge clk);
        #1;
    endtask

    task automatic peek(input string tag, input int addr, input logic [31:0] exp);
        bus.dbg_addr = RW'(addr);
        #1;
        check(tag, bus.dbg_data, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.bnd_valid = 1'b0;
        bus.bnd_data  = '0;
        bus.ld_en     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.dbg_addr  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: ADD then dependent AND
        do_load(1, 32'd5);
        do_load(2, 32'd3);
        send_bundle({mk_slot(2'd1, 4, 3, 2), mk_slot(2'd0, 3, 1, 2)});
        wait_idle();
        peek("t1_r3", 3, 32'd8);
        peek("t1_r4", 4, 32'd0);
        check("t1_zflag", bus.zflag, 1);

        // 2: SHR then NOP
        do_load(1, 32'h100);
        do_load(2, 32'd4);
        send_bundle({mk_slot(2'd3, 7, 7, 7), mk_slot(2'd2, 5, 1, 2)});
        wait_idle();
        check("t2_ready", bus.bnd_ready, 1);
        peek("t2_r5", 5, 32'h10);
        check("t2_zflag", bus.zflag, 0);

        // 3: write to r0 is dropped
        do_load(1, 32'd7);
        do_load(2, 32'd2);
        send_bundle({mk_slot(2'd0, 6, 0, 2), mk_slot(2'd0, 0, 1, 1)});
        wait_idle();
        peek("t3_r0", 0, 32'd0);
        peek("t3_r6", 6, 32'd2);

        // 4: bnd_valid held for three bundles
        begin
            int n, prev;
            bit got;
            n = 0;
            prev = 0;
            bus.bnd_valid = 1'b1;
            bus.bnd_data  = rand_bundle();
            for (int i = 0; i < 40 && n < 3; i++) begin
                @(negedge clk);
                got = bus.bnd_ready;
                if (got) begin
                    if (n > 0) check("t4_spacing", cyc - prev, NSLOT + 1);
                    prev = cyc;
                    n++;
                end
                @(posedge clk); #1;
                if (got) bus.bnd_data = rand_bundle();
            end
            bus.bnd_valid = 1'b0;
            check("t4_accepts", n, 3);
            wait_idle();
        end

        // 5: load ignored in EXEC, honoured alongside an accepted bundle
        do_load(1, 32'd7);
        send_bundle({mk_slot(2'd3, 1, 1, 1), mk_slot(2'd3, 1, 1, 1)});
        bus.ld_en   = 1'b1;
        bus.ld_addr = RW'(1);
        bus.ld_data = 32'd9;
        wait_idle();
        bus.ld_en   = 1'b0;
        peek("t5_r1_kept", 1, 32'd7);
        bus.ld_en   = 1'b1;
        bus.ld_addr = RW'(1);
        bus.ld_data = 32'd9;
        send_bundle({mk_slot(2'd3, 0, 0, 0), mk_slot(2'd0, 2, 1, 1)});
        wait_idle();
        peek("t5_r2", 2, 32'd18);

        // 6: reset during slot 1
        do_load(3, 32'd11);
        send_bundle({mk_slot(2'd0, 4, 3, 3), mk_slot(2'd0, 5, 3, 3)});
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_wb_valid", bus.wb_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < NREG; i++) peek("t6_reg_clear", i, 32'd0);
        check("t6_ready", bus.bnd_ready, 1);
        @(posedge clk); #1;

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            bus.dbg_addr = RW'($urandom_range(0, NREG - 1));
            if (kind == 0) begin
                do_load($urandom_range(0, NREG - 1), rand_val());
            end else begin
                if (kind == 1) begin
                    bus.ld_en   = 1'b1;
                    bus.ld_addr = RW'($urandom_range(0, NREG - 1));
                    bus.ld_data = rand_val();
                end
                send_bundle(rand_bundle());
                if ($urandom_range(0, 1) == 1) begin
                    bus.ld_en   = 1'b1;
                    bus.ld_addr = RW'($urandom_range(0, NREG - 1));
                    bus.ld_data = rand_val();
                end
                wait_idle();
                bus.ld_en = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check("wb_queue_drained", exp_wb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
